// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one word per frame from a FIFO read port
// and sends it as an async start/data/[parity]/stop frame on tx.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_latch,
    output logic                  tx,
    output logic                  busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nx;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nx;
    logic [IW-1:0]         idx_inc;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nx;
    logic                  tx_nx;
    logic                  busy_nx;
    logic                  bit_end;
    logic                  pop;
    logic                  par_bit;

    assign bit_end  = (cnt == CNT_LAST);
    assign idx_inc  = idx + 1'b1;
    assign par_bit  = (^shreg) ^ (PARITY_ODD != 0);

    // Pop only while idle or on the final stop cycle; never in reset.
    assign pop = reset && in_valid &&
                 ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign in_latch = pop;

    // Next-state, counter and next line-level computation.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        tx_nx    = tx;
        busy_nx  = busy;
        unique case (state)
            S_IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                cnt_nx  = '0;
                if (pop) begin
                    shreg_nx = in_data;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = S_DATA;
                    tx_nx    = shreg[0];
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nx = S_PARITY;
                            tx_nx    = par_bit;
                        end else begin
                            state_nx = S_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        idx_nx = idx_inc;
                        tx_nx  = shreg[idx_inc];
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    state_nx = S_STOP;
                    tx_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (pop) begin
                        shreg_nx = in_data;
                        state_nx = S_START;
                        tx_nx    = 1'b0;
                        busy_nx  = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                        tx_nx    = 1'b1;
                        busy_nx  = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
            tx    <= tx_nx;
            busy  <= busy_nx;
        end
    end

endmodule
